// File: rtl/if_pipe_stage.sv
// if_pipe_stage: instruction-fetch stage. Owns the program counter, drives the
// instruction-memory word address, and fills the IF/ID pipeline register.
// Stalls (Data_Hazard=0) freeze everything. Flushes (Control_Hazard=1) turn
// the word fetched this cycle into a NOP bubble. Redirect targets come from
// decode, and a jump takes priority over a taken branch.
module if_pipe_stage #(
  parameter logic [9:0] RESET_PC = 10'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Data_Hazard,
  input  logic        Control_Hazard,
  input  logic        branch_taken,
  input  logic [9:0]  branch_address,
  input  logic        jump,
  input  logic [9:0]  jump_address,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [9:0]  pc,
  output logic [9:0]  pc_plus4,
  output logic [31:0] instr,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Architectural state
  logic [9:0]  pc_q,          pc_d;
  logic [9:0]  pc_plus4_q,    pc_plus4_d;
  logic [31:0] instr_q,       instr_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  // Datapath intermediates
  logic [9:0]  seq_pc;
  logic [9:0]  next_pc;
  logic        advance;
  logic        bubble;
  logic        load_word;

  // Sequential PC with a 10-bit adder: 10'h3FC + 4 wraps to 10'h000.
  assign seq_pc = pc_q + 10'd4;

  // Hazard decode. A stall overrides a flush, so a bubble is only inserted
  // on a cycle that actually advances.
  assign advance   = Data_Hazard;
  assign bubble    = advance &  Control_Hazard;
  assign load_word = advance & ~Control_Hazard;

  // Next-PC select: jump beats branch, and branch beats the sequential PC.
  // Targets are used as given. Their low two bits only drop out of imem_addr.
  always_comb begin
    next_pc = seq_pc;
    if (jump) begin
      next_pc = jump_address;
    end else if (branch_taken) begin
      next_pc = branch_address;
    end
  end

  // PC next-state: hold on stall, even if a redirect is pending. The branch
  // is still in decode and resolves again on the cycle the stall clears.
  always_comb begin
    pc_d = pc_q;
    if (advance) begin
      pc_d = next_pc;
    end
  end

  // IF/ID next-state: hold on stall, load a bubble on flush, else capture fetch.
  always_comb begin
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (bubble) begin
      pc_plus4_d = 10'h000;
      instr_d    = NOP_WORD;
    end else if (load_word) begin
      pc_plus4_d = seq_pc;
      instr_d    = imem_rdata;
    end
  end

  // Fetch counter next-state: count only real words entering IF/ID.
  // The count wraps naturally at 16 bits.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (load_word) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  // State registers. Reset is asynchronous and may arrive mid-stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      pc_plus4_q    <= 10'h000;
      instr_q       <= NOP_WORD;
      fetch_count_q <= 16'h0000;
    end else begin
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_q       <= instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Outputs. The memory address follows the PC register combinationally.
  assign imem_addr   = pc_q[9:2];
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign instr       = instr_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_pipe_stage.sv
// Directed testbench for if_pipe_stage. The instruction memory model returns
// 32'h1000_0000 + word index.
module tb_if_pipe_stage;

  logic        clk;
  logic        reset;
  logic        Data_Hazard;
  logic        Control_Hazard;
  logic        branch_taken;
  logic [9:0]  branch_address;
  logic        jump;
  logic [9:0]  jump_address;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [9:0]  pc;
  logic [9:0]  pc_plus4;
  logic [31:0] instr;
  logic [15:0] fetch_count;

  int checks;
  int errors;

  if_pipe_stage #(.RESET_PC(10'd0)) dut (
    .clk            (clk),
    .reset          (reset),
    .Data_Hazard    (Data_Hazard),
    .Control_Hazard (Control_Hazard),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .jump           (jump),
    .jump_address   (jump_address),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .instr          (instr),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = 32'h1000_0000 + {24'h0, imem_addr};

  // One rising edge, then settle. Inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
    $display("[%0t] DH=%0b CH=%0b br=%0b j=%0b -> pc=%h pc_plus4=%h instr=%h fc=%0d",
             $time, Data_Hazard, Control_Hazard, branch_taken, jump,
             pc, pc_plus4, instr, fetch_count);
  endtask

  task automatic clear_redirect();
    Control_Hazard = 1'b0;
    branch_taken   = 1'b0;
    jump           = 1'b0;
    branch_address = 10'h000;
    jump_address   = 10'h000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Data_Hazard = 1'b1;
    clear_redirect();
    step();
    step();
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 10'h000); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_imem_addr got=%h exp=%h", imem_addr, 8'h00); end
    checks++; if (pc_plus4 !== 10'h000) begin errors++; $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4, 10'h000); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'h0); end
    checks++; if (fetch_count !== 16'h0) begin errors++; $display("FAIL reset_fetch_count got=%0d exp=%0d", fetch_count, 0); end
    // Release between edges. The next edge must be a normal fetch from RESET_PC.
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    step();
    checks++; if (instr !== 32'h1000_0000) begin errors++; $display("FAIL first_fetch_instr got=%h exp=%h", instr, 32'h1000_0000); end
    checks++; if (pc_plus4 !== 10'd4) begin errors++; $display("FAIL first_fetch_pc_plus4 got=%h exp=%h", pc_plus4, 10'd4); end
    step();
    step();
    checks++; if (pc !== 10'd12) begin errors++; $display("FAIL run_pc got=%h exp=%h", pc, 10'd12); end
    checks++; if (imem_addr !== 8'd3) begin errors++; $display("FAIL run_imem_addr got=%h exp=%h", imem_addr, 8'd3); end
    checks++; if (instr !== 32'h1000_0002) begin errors++; $display("FAIL run_instr got=%h exp=%h", instr, 32'h1000_0002); end
    checks++; if (pc_plus4 !== 10'd12) begin errors++; $display("FAIL run_pc_plus4 got=%h exp=%h", pc_plus4, 10'd12); end
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL run_fetch_count got=%0d exp=%0d", fetch_count, 3); end
  endtask

  task automatic test_stall();
    // Restart so that pc=8: after two fetches, instr=imem[1] and pc_plus4=8.
    reset = 1'b1; #1; reset = 1'b0;
    step();
    step();
    checks++; if (pc !== 10'd8) begin errors++; $display("FAIL stall_setup_pc got=%h exp=%h", pc, 10'd8); end
    Data_Hazard = 1'b0;
    step();
    step();
    checks++; if (pc !== 10'd8) begin errors++; $display("FAIL stall_pc got=%h exp=%h", pc, 10'd8); end
    checks++; if (instr !== 32'h1000_0001) begin errors++; $display("FAIL stall_instr got=%h exp=%h", instr, 32'h1000_0001); end
    checks++; if (pc_plus4 !== 10'd8) begin errors++; $display("FAIL stall_pc_plus4 got=%h exp=%h", pc_plus4, 10'd8); end
    checks++; if (fetch_count !== 16'd2) begin errors++; $display("FAIL stall_fetch_count got=%0d exp=%0d", fetch_count, 2); end
    Data_Hazard = 1'b1;
    step();
    checks++; if (pc !== 10'd12) begin errors++; $display("FAIL stall_release_pc got=%h exp=%h", pc, 10'd12); end
    checks++; if (instr !== 32'h1000_0002) begin errors++; $display("FAIL stall_release_instr got=%h exp=%h", instr, 32'h1000_0002); end
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL stall_release_fc got=%0d exp=%0d", fetch_count, 3); end
  endtask

  task automatic test_branch();
    step(); // pc 12 -> 16, fc=4
    checks++; if (pc !== 10'd16) begin errors++; $display("FAIL branch_setup_pc got=%h exp=%h", pc, 10'd16); end
    branch_taken = 1'b1; branch_address = 10'h040; Control_Hazard = 1'b1;
    step();
    checks++; if (pc !== 10'h040) begin errors++; $display("FAIL branch_pc got=%h exp=%h", pc, 10'h040); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL branch_bubble_instr got=%h exp=%h", instr, 32'h0); end
    checks++; if (pc_plus4 !== 10'h000) begin errors++; $display("FAIL branch_bubble_pc_plus4 got=%h exp=%h", pc_plus4, 10'h000); end
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL branch_fc got=%0d exp=%0d", fetch_count, 4); end
    clear_redirect();
    step();
    checks++; if (instr !== 32'h1000_0010) begin errors++; $display("FAIL branch_target_instr got=%h exp=%h", instr, 32'h1000_0010); end
    checks++; if (pc_plus4 !== 10'h044) begin errors++; $display("FAIL branch_target_pc_plus4 got=%h exp=%h", pc_plus4, 10'h044); end
    checks++; if (fetch_count !== 16'd5) begin errors++; $display("FAIL branch_target_fc got=%0d exp=%0d", fetch_count, 5); end
  endtask

  task automatic test_jump_over_branch();
    jump = 1'b1; jump_address = 10'h100;
    branch_taken = 1'b1; branch_address = 10'h040; Control_Hazard = 1'b1;
    step();
    checks++; if (pc !== 10'h100) begin errors++; $display("FAIL jump_pc got=%h exp=%h", pc, 10'h100); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL jump_bubble_instr got=%h exp=%h", instr, 32'h0); end
    clear_redirect();
    step();
    checks++; if (instr !== 32'h1000_0040) begin errors++; $display("FAIL jump_target_instr got=%h exp=%h", instr, 32'h1000_0040); end
    checks++; if (pc !== 10'h104) begin errors++; $display("FAIL jump_next_pc got=%h exp=%h", pc, 10'h104); end
    checks++; if (fetch_count !== 16'd6) begin errors++; $display("FAIL jump_fc got=%0d exp=%0d", fetch_count, 6); end
  endtask

  task automatic test_stall_beats_redirect();
    branch_taken = 1'b1; branch_address = 10'h080; Control_Hazard = 1'b1; Data_Hazard = 1'b0;
    step();
    checks++; if (pc !== 10'h104) begin errors++; $display("FAIL sbr_pc got=%h exp=%h", pc, 10'h104); end
    checks++; if (instr !== 32'h1000_0040) begin errors++; $display("FAIL sbr_instr got=%h exp=%h", instr, 32'h1000_0040); end
    checks++; if (pc_plus4 !== 10'h104) begin errors++; $display("FAIL sbr_pc_plus4 got=%h exp=%h", pc_plus4, 10'h104); end
    Data_Hazard = 1'b1;
    step();
    checks++; if (pc !== 10'h080) begin errors++; $display("FAIL sbr_release_pc got=%h exp=%h", pc, 10'h080); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL sbr_release_instr got=%h exp=%h", instr, 32'h0); end
    checks++; if (fetch_count !== 16'd6) begin errors++; $display("FAIL sbr_release_fc got=%0d exp=%0d", fetch_count, 6); end
    clear_redirect();
  endtask

  task automatic test_flush_no_redirect();
    Control_Hazard = 1'b1;
    step();
    checks++; if (pc !== 10'h084) begin errors++; $display("FAIL flush_pc got=%h exp=%h", pc, 10'h084); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL flush_instr got=%h exp=%h", instr, 32'h0); end
    checks++; if (fetch_count !== 16'd6) begin errors++; $display("FAIL flush_fc got=%0d exp=%0d", fetch_count, 6); end
    clear_redirect();
    step();
    checks++; if (instr !== 32'h1000_0021) begin errors++; $display("FAIL flush_next_instr got=%h exp=%h", instr, 32'h1000_0021); end
    checks++; if (pc_plus4 !== 10'h088) begin errors++; $display("FAIL flush_next_pc_plus4 got=%h exp=%h", pc_plus4, 10'h088); end
  endtask

  task automatic test_unaligned_and_wrap();
    // An unaligned target is kept in the PC, but imem_addr drops bits [1:0].
    jump = 1'b1; jump_address = 10'h3FF; Control_Hazard = 1'b1;
    step();
    checks++; if (pc !== 10'h3FF) begin errors++; $display("FAIL unaligned_pc got=%h exp=%h", pc, 10'h3FF); end
    checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL unaligned_imem_addr got=%h exp=%h", imem_addr, 8'hFF); end
    jump_address = 10'h3FC;
    step();
    clear_redirect();
    step();
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc, 10'h000); end
    checks++; if (pc_plus4 !== 10'h000) begin errors++; $display("FAIL wrap_pc_plus4 got=%h exp=%h", pc_plus4, 10'h000); end
    checks++; if (instr !== 32'h1000_00FF) begin errors++; $display("FAIL wrap_instr got=%h exp=%h", instr, 32'h1000_00FF); end
    checks++; if (fetch_count !== 16'd8) begin errors++; $display("FAIL wrap_fc got=%0d exp=%0d", fetch_count, 8); end
  endtask

  task automatic test_async_reset();
    step();
    Data_Hazard = 1'b0; // reset must override a stall
    #2;                 // mid-cycle, well away from any clock edge
    reset = 1'b1;
    #1;
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL areset_pc got=%h exp=%h", pc, 10'h000); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL areset_imem_addr got=%h exp=%h", imem_addr, 8'h00); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL areset_instr got=%h exp=%h", instr, 32'h0); end
    checks++; if (pc_plus4 !== 10'h000) begin errors++; $display("FAIL areset_pc_plus4 got=%h exp=%h", pc_plus4, 10'h000); end
    checks++; if (fetch_count !== 16'h0) begin errors++; $display("FAIL areset_fc got=%0d exp=%0d", fetch_count, 0); end
    #1;
    reset = 1'b0;
    Data_Hazard = 1'b1;
    step();
    checks++; if (instr !== 32'h1000_0000) begin errors++; $display("FAIL post_reset_instr got=%h exp=%h", instr, 32'h1000_0000); end
    checks++; if (pc !== 10'd4) begin errors++; $display("FAIL post_reset_pc got=%h exp=%h", pc, 10'd4); end
    checks++; if (fetch_count !== 16'd1) begin errors++; $display("FAIL post_reset_fc got=%0d exp=%0d", fetch_count, 1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_jump_over_branch();
    test_stall_beats_redirect();
    test_flush_no_redirect();
    test_unaligned_and_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
